// File: rtl/rr_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rr_control_sequencer
//  Purpose  : Moore control FSM for instruction fetch (T0-T2) and
//             register-register ALU / MUL / DIV execute (T3-T6).
//  Revision : 1.0  initial release
// ============================================================================
module rr_control_sequencer #(
    parameter int OPW  = 5,
    parameter int REGW = 4,
    parameter int NREG = 16
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic            Start,
    input  logic            MemReady,
    input  logic [31:0]     IR,
    output logic            PCout,
    output logic            Zhiout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            MARin,
    output logic            Zin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            HIin,
    output logic            LOin,
    output logic            IncPC,
    output logic            Read,
    output logic            ADD,
    output logic            SUB,
    output logic            AND,
    output logic            OR,
    output logic            MUL,
    output logic            DIV,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin,
    output logic            Busy,
    output logic            Done,
    output logic            Illegal
);

    localparam logic [3:0] c_st_idle = 4'd0;
    localparam logic [3:0] c_st_t0   = 4'd1;
    localparam logic [3:0] c_st_t1   = 4'd2;
    localparam logic [3:0] c_st_t1w  = 4'd3;
    localparam logic [3:0] c_st_t2   = 4'd4;
    localparam logic [3:0] c_st_t3   = 4'd5;
    localparam logic [3:0] c_st_t4   = 4'd6;
    localparam logic [3:0] c_st_t5   = 4'd7;
    localparam logic [3:0] c_st_t6   = 4'd8;
    localparam logic [3:0] c_st_done = 4'd9;

    localparam logic [OPW-1:0]  c_op_add  = OPW'(3);
    localparam logic [OPW-1:0]  c_op_sub  = OPW'(4);
    localparam logic [OPW-1:0]  c_op_and  = OPW'(5);
    localparam logic [OPW-1:0]  c_op_or   = OPW'(6);
    localparam logic [OPW-1:0]  c_op_mul  = OPW'(15);
    localparam logic [OPW-1:0]  c_op_div  = OPW'(16);
    localparam logic [REGW:0]   c_nreg    = (REGW+1)'(NREG);
    localparam logic [NREG-1:0] c_one     = NREG'(1);
    localparam int              c_used_bits = OPW + 3*REGW;

    logic [3:0]      r_state;
    logic [3:0]      w_state_nxt;
    logic [OPW-1:0]  w_op;
    logic [REGW-1:0] w_ra;
    logic [REGW-1:0] w_rb;
    logic [REGW-1:0] w_rc;
    logic            w_op_alu;
    logic            w_op_md;
    logic            w_illegal;

    // Fields are packed from bit 31 downward: op, Ra, Rb, Rc.
    assign w_op = IR[31 -: OPW];
    assign w_ra = IR[31-OPW -: REGW];
    assign w_rb = IR[31-OPW-REGW -: REGW];
    assign w_rc = IR[31-OPW-2*REGW -: REGW];

    generate
        if (c_used_bits < 32) begin : g_unused_ir
            logic w_unused_ir;
            assign w_unused_ir = ^IR[31-c_used_bits:0];
        end
    endgenerate

    assign w_op_alu = (w_op == c_op_add) || (w_op == c_op_sub) ||
                      (w_op == c_op_and) || (w_op == c_op_or);
    assign w_op_md  = (w_op == c_op_mul) || (w_op == c_op_div);

    // Ra is only a destination for single-result ops; MUL/DIV write HI/LO.
    assign w_illegal = !(w_op_alu || w_op_md) ||
                       ({1'b0, w_rb} >= c_nreg) ||
                       ({1'b0, w_rc} >= c_nreg) ||
                       (!w_op_md && ({1'b0, w_ra} >= c_nreg));

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        PCout   = 1'b0;  Zhiout = 1'b0;  Zlowout = 1'b0;  MDRout = 1'b0;
        MARin   = 1'b0;  Zin    = 1'b0;  PCin    = 1'b0;  MDRin  = 1'b0;
        IRin    = 1'b0;  Yin    = 1'b0;  HIin    = 1'b0;  LOin   = 1'b0;
        IncPC   = 1'b0;  Read   = 1'b0;
        ADD     = 1'b0;  SUB    = 1'b0;  AND     = 1'b0;  OR     = 1'b0;
        MUL     = 1'b0;  DIV    = 1'b0;
        Rout    = '0;    Rin    = '0;
        Busy    = (r_state != c_st_idle);
        Done    = 1'b0;
        Illegal = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (Start) w_state_nxt = c_st_t0;
            end
            c_st_t0: begin
                PCout = 1'b1;  MARin = 1'b1;  IncPC = 1'b1;  Zin = 1'b1;
                w_state_nxt = c_st_t1;
            end
            c_st_t1: begin
                Zlowout = 1'b1;  PCin = 1'b1;  Read = 1'b1;  MDRin = 1'b1;
                w_state_nxt = MemReady ? c_st_t2 : c_st_t1w;
            end
            c_st_t1w: begin
                Read = 1'b1;  MDRin = 1'b1;
                if (MemReady) w_state_nxt = c_st_t2;
            end
            c_st_t2: begin
                MDRout = 1'b1;  IRin = 1'b1;
                w_state_nxt = c_st_t3;
            end
            c_st_t3: begin
                if (w_illegal) begin
                    Illegal     = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    Rout        = c_one << w_rb;
                    Yin         = 1'b1;
                    w_state_nxt = c_st_t4;
                end
            end
            c_st_t4: begin
                Rout = c_one << w_rc;
                Zin  = 1'b1;
                ADD  = (w_op == c_op_add);
                SUB  = (w_op == c_op_sub);
                AND  = (w_op == c_op_and);
                OR   = (w_op == c_op_or);
                MUL  = (w_op == c_op_mul);
                DIV  = (w_op == c_op_div);
                w_state_nxt = c_st_t5;
            end
            c_st_t5: begin
                Zlowout = 1'b1;
                if (w_op_md) begin
                    LOin        = 1'b1;
                    w_state_nxt = c_st_t6;
                end else begin
                    Rin         = c_one << w_ra;
                    w_state_nxt = c_st_done;
                end
            end
            c_st_t6: begin
                Zhiout = 1'b1;  HIin = 1'b1;
                w_state_nxt = c_st_done;
            end
            c_st_done: begin
                Done        = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_control_sequencer
//  Purpose  : Directed self-checking bench for rr_control_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_control_sequencer;

    localparam logic [22:0] c_pcout   = 23'h1 << 22;
    localparam logic [22:0] c_zhiout  = 23'h1 << 21;
    localparam logic [22:0] c_zlowout = 23'h1 << 20;
    localparam logic [22:0] c_mdrout  = 23'h1 << 19;
    localparam logic [22:0] c_marin   = 23'h1 << 18;
    localparam logic [22:0] c_zin     = 23'h1 << 17;
    localparam logic [22:0] c_pcin    = 23'h1 << 16;
    localparam logic [22:0] c_mdrin   = 23'h1 << 15;
    localparam logic [22:0] c_irin    = 23'h1 << 14;
    localparam logic [22:0] c_yin     = 23'h1 << 13;
    localparam logic [22:0] c_hiin    = 23'h1 << 12;
    localparam logic [22:0] c_loin    = 23'h1 << 11;
    localparam logic [22:0] c_incpc   = 23'h1 << 10;
    localparam logic [22:0] c_read    = 23'h1 << 9;
    localparam logic [22:0] c_add     = 23'h1 << 8;
    localparam logic [22:0] c_sub     = 23'h1 << 7;
    localparam logic [22:0] c_and     = 23'h1 << 6;
    localparam logic [22:0] c_or      = 23'h1 << 5;
    localparam logic [22:0] c_mul     = 23'h1 << 4;
    localparam logic [22:0] c_div     = 23'h1 << 3;
    localparam logic [22:0] c_busy    = 23'h1 << 2;
    localparam logic [22:0] c_done    = 23'h1 << 1;
    localparam logic [22:0] c_ill     = 23'h1;

    localparam logic [22:0] c_e_t0   = c_pcout | c_marin | c_incpc | c_zin | c_busy;
    localparam logic [22:0] c_e_t1   = c_zlowout | c_pcin | c_read | c_mdrin | c_busy;
    localparam logic [22:0] c_e_t1w  = c_read | c_mdrin | c_busy;
    localparam logic [22:0] c_e_t2   = c_mdrout | c_irin | c_busy;
    localparam logic [22:0] c_e_t3   = c_yin | c_busy;
    localparam logic [22:0] c_e_t5a  = c_zlowout | c_busy;
    localparam logic [22:0] c_e_t5m  = c_zlowout | c_loin | c_busy;
    localparam logic [22:0] c_e_t6   = c_zhiout | c_hiin | c_busy;
    localparam logic [22:0] c_e_done = c_done | c_busy;
    localparam logic [22:0] c_e_ill  = c_ill | c_busy;

    logic        Clock;
    logic        Clear;
    logic        Start;
    logic        MemReady;
    logic [31:0] IR;

    logic PCout, Zhiout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic HIin, LOin, IncPC, Read, ADD, SUB, AND, OR, MUL, DIV, Busy, Done, Illegal;
    logic [15:0] Rout, Rin;

    logic PCout8, Zhiout8, Zlowout8, MDRout8, MARin8, Zin8, PCin8, MDRin8, IRin8, Yin8;
    logic HIin8, LOin8, IncPC8, Read8, ADD8, SUB8, AND8, OR8, MUL8, DIV8, Busy8, Done8, Illegal8;
    logic [7:0] Rout8, Rin8;

    logic [22:0] w_ctl;
    logic [22:0] w_ctl8;

    int n_cmp = 0;
    int n_err = 0;

    rr_control_sequencer #(.OPW(5), .REGW(4), .NREG(16)) u_dut (
        .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(IR),
        .PCout(PCout), .Zhiout(Zhiout), .Zlowout(Zlowout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .MUL(MUL), .DIV(DIV),
        .Rout(Rout), .Rin(Rin), .Busy(Busy), .Done(Done), .Illegal(Illegal)
    );

    rr_control_sequencer #(.OPW(5), .REGW(4), .NREG(8)) u_dut8 (
        .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(IR),
        .PCout(PCout8), .Zhiout(Zhiout8), .Zlowout(Zlowout8), .MDRout(MDRout8),
        .MARin(MARin8), .Zin(Zin8), .PCin(PCin8), .MDRin(MDRin8), .IRin(IRin8),
        .Yin(Yin8), .HIin(HIin8), .LOin(LOin8), .IncPC(IncPC8), .Read(Read8),
        .ADD(ADD8), .SUB(SUB8), .AND(AND8), .OR(OR8), .MUL(MUL8), .DIV(DIV8),
        .Rout(Rout8), .Rin(Rin8), .Busy(Busy8), .Done(Done8), .Illegal(Illegal8)
    );

    assign w_ctl = {PCout, Zhiout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                    Yin, HIin, LOin, IncPC, Read, ADD, SUB, AND, OR, MUL, DIV,
                    Busy, Done, Illegal};
    assign w_ctl8 = {PCout8, Zhiout8, Zlowout8, MDRout8, MARin8, Zin8, PCin8, MDRin8,
                     IRin8, Yin8, HIin8, LOin8, IncPC8, Read8, ADD8, SUB8, AND8, OR8,
                     MUL8, DIV8, Busy8, Done8, Illegal8};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then compare the full control word of the NREG=16 unit.
    task automatic step(input string tag, input logic [22:0] ec,
                        input logic [15:0] er, input logic [15:0] ei);
        @(posedge Clock);
        #1;
        check({tag, ".ctl"},  {9'd0, w_ctl}, {9'd0, ec});
        check({tag, ".rout"}, {16'd0, Rout}, {16'd0, er});
        check({tag, ".rin"},  {16'd0, Rin},  {16'd0, ei});
    endtask

    initial begin
        Clear    = 1'b0;
        Start    = 1'b0;
        MemReady = 1'b1;
        IR       = 32'h0;

        step("rst0", 23'h0, 16'h0, 16'h0);
        Start = 1'b1;
        step("rst1", 23'h0, 16'h0, 16'h0);
        Start = 1'b0;
        Clear = 1'b1;
        step("idle", 23'h0, 16'h0, 16'h0);

        // SUB R5 = R2 - R4
        IR = 32'h22920000;
        Start = 1'b1;
        step("sub.t0", c_e_t0, 16'h0, 16'h0);
        Start = 1'b0;
        step("sub.t1", c_e_t1, 16'h0, 16'h0);
        step("sub.t2", c_e_t2, 16'h0, 16'h0);
        step("sub.t3", c_e_t3, 16'h0004, 16'h0);
        step("sub.t4", c_zin | c_sub | c_busy, 16'h0010, 16'h0);
        step("sub.t5", c_e_t5a, 16'h0, 16'h0020);
        step("sub.dn", c_e_done, 16'h0, 16'h0);
        step("sub.id", 23'h0, 16'h0, 16'h0);

        // MUL Rb=3 Rc=1
        IR = 32'h78188000;
        Start = 1'b1;
        step("mul.t0", c_e_t0, 16'h0, 16'h0);
        Start = 1'b0;
        step("mul.t1", c_e_t1, 16'h0, 16'h0);
        step("mul.t2", c_e_t2, 16'h0, 16'h0);
        step("mul.t3", c_e_t3, 16'h0008, 16'h0);
        step("mul.t4", c_zin | c_mul | c_busy, 16'h0002, 16'h0);
        step("mul.t5", c_e_t5m, 16'h0, 16'h0);
        step("mul.t6", c_e_t6, 16'h0, 16'h0);
        step("mul.dn", c_e_done, 16'h0, 16'h0);
        step("mul.id", 23'h0, 16'h0, 16'h0);

        // SUB with three memory wait cycles
        IR = 32'h22920000;
        Start = 1'b1;
        step("wt.t0", c_e_t0, 16'h0, 16'h0);
        Start = 1'b0;
        MemReady = 1'b0;
        step("wt.t1", c_e_t1, 16'h0, 16'h0);
        step("wt.w1", c_e_t1w, 16'h0, 16'h0);
        step("wt.w2", c_e_t1w, 16'h0, 16'h0);
        step("wt.w3", c_e_t1w, 16'h0, 16'h0);
        MemReady = 1'b1;
        step("wt.t2", c_e_t2, 16'h0, 16'h0);
        step("wt.t3", c_e_t3, 16'h0004, 16'h0);
        step("wt.t4", c_zin | c_sub | c_busy, 16'h0010, 16'h0);
        step("wt.t5", c_e_t5a, 16'h0, 16'h0020);
        step("wt.dn", c_e_done, 16'h0, 16'h0);
        step("wt.id", 23'h0, 16'h0, 16'h0);

        // Unknown opcode 31
        IR = 32'hF8000000;
        Start = 1'b1;
        step("ill.t0", c_e_t0, 16'h0, 16'h0);
        Start = 1'b0;
        step("ill.t1", c_e_t1, 16'h0, 16'h0);
        step("ill.t2", c_e_t2, 16'h0, 16'h0);
        step("ill.t3", c_e_ill, 16'h0, 16'h0);
        step("ill.id", 23'h0, 16'h0, 16'h0);
        step("ill.id2", 23'h0, 16'h0, 16'h0);

        // ADD Ra=0 Rb=9 Rc=0: legal with 16 registers, illegal with 8
        IR = 32'h18480000;
        Start = 1'b1;
        step("rb9.t0", c_e_t0, 16'h0, 16'h0);
        Start = 1'b0;
        step("rb9.t1", c_e_t1, 16'h0, 16'h0);
        step("rb9.t2", c_e_t2, 16'h0, 16'h0);
        step("rb9.t3", c_e_t3, 16'h0200, 16'h0);
        check("rb9.n8.t3.ctl",  {9'd0, w_ctl8}, {9'd0, c_e_ill});
        check("rb9.n8.t3.rout", {24'd0, Rout8}, 32'h0);
        step("rb9.t4", c_zin | c_add | c_busy, 16'h0001, 16'h0);
        check("rb9.n8.idle", {9'd0, w_ctl8}, 32'h0);
        step("rb9.t5", c_e_t5a, 16'h0, 16'h0001);
        check("rb9.n8.nodone", {31'd0, Done8}, 32'h0);
        step("rb9.dn", c_e_done, 16'h0, 16'h0);
        step("rb9.id", 23'h0, 16'h0, 16'h0);

        // MUL with Ra=9 on 8 registers is still legal
        IR = 32'h7C890000;
        Start = 1'b1;
        step("mra.t0", c_e_t0, 16'h0, 16'h0);
        Start = 1'b0;
        step("mra.t1", c_e_t1, 16'h0, 16'h0);
        step("mra.t2", c_e_t2, 16'h0, 16'h0);
        step("mra.t3", c_e_t3, 16'h0002, 16'h0);
        check("mra.n8.t3.ctl",  {9'd0, w_ctl8}, {9'd0, c_e_t3});
        check("mra.n8.t3.rout", {24'd0, Rout8}, 32'h2);
        step("mra.t4", c_zin | c_mul | c_busy, 16'h0004, 16'h0);
        step("mra.t5", c_e_t5m, 16'h0, 16'h0);
        step("mra.t6", c_e_t6, 16'h0, 16'h0);
        step("mra.dn", c_e_done, 16'h0, 16'h0);
        check("mra.n8.dn", {9'd0, w_ctl8}, {9'd0, c_e_done});
        step("mra.id", 23'h0, 16'h0, 16'h0);

        // ADD R1 = R2 + R3, cleared during T4
        IR = 32'h18918000;
        Start = 1'b1;
        step("clr.t0", c_e_t0, 16'h0, 16'h0);
        Start = 1'b0;
        step("clr.t1", c_e_t1, 16'h0, 16'h0);
        step("clr.t2", c_e_t2, 16'h0, 16'h0);
        step("clr.t3", c_e_t3, 16'h0004, 16'h0);
        step("clr.t4", c_zin | c_add | c_busy, 16'h0008, 16'h0);
        Clear = 1'b0;
        Start = 1'b1;
        step("clr.a", 23'h0, 16'h0, 16'h0);
        step("clr.b", 23'h0, 16'h0, 16'h0);
        step("clr.c", 23'h0, 16'h0, 16'h0);

        // Back-to-back with Start held high
        Clear = 1'b1;
        step("b2b.t0", c_e_t0, 16'h0, 16'h0);
        step("b2b.t1", c_e_t1, 16'h0, 16'h0);
        step("b2b.t2", c_e_t2, 16'h0, 16'h0);
        step("b2b.t3", c_e_t3, 16'h0004, 16'h0);
        step("b2b.t4", c_zin | c_add | c_busy, 16'h0008, 16'h0);
        step("b2b.t5", c_e_t5a, 16'h0, 16'h0002);
        step("b2b.dn", c_e_done, 16'h0, 16'h0);
        step("b2b.id", 23'h0, 16'h0, 16'h0);
        step("b2b.t0b", c_e_t0, 16'h0, 16'h0);
        step("b2b.t1b", c_e_t1, 16'h0, 16'h0);
        step("b2b.t2b", c_e_t2, 16'h0, 16'h0);
        step("b2b.t3b", c_e_t3, 16'h0004, 16'h0);
        step("b2b.t4b", c_zin | c_add | c_busy, 16'h0008, 16'h0);
        step("b2b.t5b", c_e_t5a, 16'h0, 16'h0002);
        step("b2b.dnb", c_e_done, 16'h0, 16'h0);
        Start = 1'b0;
        step("b2b.idb", 23'h0, 16'h0, 16'h0);
        step("b2b.idc", 23'h0, 16'h0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
